// File: rtl/peridot_ft245_chmux.sv
// peridot_ft245_chmux
//   Channel multiplexer in front of the FT245 phy byte streams.
//   TX: round-robin, packet-granular arbitration of CHANNELS byte sources onto
//       one phy stream. A header (0x7C, ch) is inserted whenever the owning
//       channel changes. Payload bytes 0x7C/0x7D are escaped as 0x7D, b^0x20.
//   RX: parses the same framing and steers payload to per-channel sinks.
// Ports:
//   clock_sig, reset_sig (async, active-high)
//   phy_in_*    : byte stream to the phy TX sink
//   phy_out_*   : byte stream from the phy RX source
//   tx_*        : per-channel TX sinks (tx_data channel i at [8i+7:8i])
//   rx_*        : per-channel RX sources (rx_data shared by all channels)
// Optional feature (macro PERIDOT_FT245_CHMUX_BURSTLIMIT_EN):
//   releases a grant after BURST_LIMIT payload bytes without eop.
module peridot_ft245_chmux #(
    parameter int CHANNELS    = 2,
    parameter int BURST_LIMIT = 64
) (
    input  logic                    clock_sig,
    input  logic                    reset_sig,
    input  logic                    phy_in_ready,
    output logic                    phy_in_valid,
    output logic [7:0]              phy_in_data,
    output logic                    phy_out_ready,
    input  logic                    phy_out_valid,
    input  logic [7:0]              phy_out_data,
    input  logic [CHANNELS-1:0]     tx_valid,
    input  logic [8*CHANNELS-1:0]   tx_data,
    input  logic [CHANNELS-1:0]     tx_eop,
    output logic [CHANNELS-1:0]     tx_ready,
    output logic [CHANNELS-1:0]     rx_valid,
    output logic [7:0]              rx_data,
    input  logic [CHANNELS-1:0]     rx_ready
);
    localparam int         CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [7:0] MARK = 8'h7C;
    localparam logic [7:0] ESC  = 8'h7D;

    // ---------------------------------------------------------------- TX
    typedef enum logic [2:0] {T_IDLE, T_HDR_MARK, T_HDR_CH, T_DATA, T_ESC_DATA} tx_st_t;

    tx_st_t          tx_st_q, tx_st_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   cur_ch_q, cur_ch_d;
    logic            cur_vld_q, cur_vld_d;   // 0 = no owner yet, forces a header
    logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            obuf_vld_q, obuf_vld_d;
    logic [7:0]      obuf_data_q, obuf_data_d;
    logic [7:0]      esc_byte_q, esc_byte_d;
    logic            esc_last_q, esc_last_d; // escaped byte ends the grant

    logic            can_load, rr_hit, g_valid, g_eop, burst_hit, rel;
    logic [CW-1:0]   rr_g, g_next;
    logic [7:0]      g_data;
    int              idx;

`ifdef PERIDOT_FT245_CHMUX_BURSTLIMIT_EN
    logic [7:0]      burst_cnt_q, burst_cnt_d;
    assign burst_hit = (burst_cnt_q == 8'(BURST_LIMIT - 1));
`else
    assign burst_hit = 1'b0;
`endif

    assign can_load     = ~obuf_vld_q | phy_in_ready;
    assign g_valid      = tx_valid[grant_q];
    assign g_eop        = tx_eop[grant_q];
    assign g_data       = tx_data[8*grant_q +: 8];
    assign rel          = g_eop | burst_hit;
    assign g_next       = (grant_q == CW'(CHANNELS - 1)) ? '0 : grant_q + CW'(1);
    assign phy_in_valid = obuf_vld_q;
    assign phy_in_data  = obuf_data_q;

    // First requester at or after rr_ptr; descending scan so the nearest wins.
    always_comb begin
        rr_hit = 1'b0;
        rr_g   = '0;
        idx    = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (tx_valid[idx]) begin
                rr_hit = 1'b1;
                rr_g   = CW'(idx);
            end
        end
    end

    always_comb begin
        tx_st_d     = tx_st_q;
        grant_d     = grant_q;
        cur_ch_d    = cur_ch_q;
        cur_vld_d   = cur_vld_q;
        rr_ptr_d    = rr_ptr_q;
        obuf_vld_d  = obuf_vld_q & ~phy_in_ready;
        obuf_data_d = obuf_data_q;
        esc_byte_d  = esc_byte_q;
        esc_last_d  = esc_last_q;
        tx_ready    = '0;
`ifdef PERIDOT_FT245_CHMUX_BURSTLIMIT_EN
        burst_cnt_d = burst_cnt_q;
`endif
        case (tx_st_q)
            T_IDLE: if (rr_hit) begin
                grant_d = rr_g;
`ifdef PERIDOT_FT245_CHMUX_BURSTLIMIT_EN
                burst_cnt_d = '0;
`endif
                tx_st_d = (cur_vld_q && rr_g == cur_ch_q) ? T_DATA : T_HDR_MARK;
            end
            T_HDR_MARK: if (can_load) begin
                obuf_vld_d  = 1'b1;
                obuf_data_d = MARK;
                tx_st_d     = T_HDR_CH;
            end
            T_HDR_CH: if (can_load) begin
                obuf_vld_d  = 1'b1;
                obuf_data_d = 8'(grant_q);
                cur_ch_d    = grant_q;
                cur_vld_d   = 1'b1;
                tx_st_d     = T_DATA;
            end
            T_DATA: if (can_load && g_valid) begin
                tx_ready[grant_q] = 1'b1;
                obuf_vld_d        = 1'b1;
`ifdef PERIDOT_FT245_CHMUX_BURSTLIMIT_EN
                burst_cnt_d = burst_cnt_q + 8'd1;
`endif
                if (rel) rr_ptr_d = g_next;
                if (g_data == MARK || g_data == ESC) begin
                    obuf_data_d = ESC;
                    esc_byte_d  = g_data;
                    esc_last_d  = rel;
                    tx_st_d     = T_ESC_DATA;
                end else begin
                    obuf_data_d = g_data;
                    if (rel) tx_st_d = T_IDLE;
                end
            end
            T_ESC_DATA: if (can_load) begin
                obuf_vld_d  = 1'b1;
                obuf_data_d = esc_byte_q ^ 8'h20;
                tx_st_d     = esc_last_q ? T_IDLE : T_DATA;
            end
            default: tx_st_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            tx_st_q     <= T_IDLE;
            grant_q     <= '0;
            cur_ch_q    <= '0;
            cur_vld_q   <= 1'b0;
            rr_ptr_q    <= '0;
            obuf_vld_q  <= 1'b0;
            obuf_data_q <= '0;
            esc_byte_q  <= '0;
            esc_last_q  <= 1'b0;
        end else begin
            tx_st_q     <= tx_st_d;
            grant_q     <= grant_d;
            cur_ch_q    <= cur_ch_d;
            cur_vld_q   <= cur_vld_d;
            rr_ptr_q    <= rr_ptr_d;
            obuf_vld_q  <= obuf_vld_d;
            obuf_data_q <= obuf_data_d;
            esc_byte_q  <= esc_byte_d;
            esc_last_q  <= esc_last_d;
        end
    end

`ifdef PERIDOT_FT245_CHMUX_BURSTLIMIT_EN
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) burst_cnt_q <= '0;
        else           burst_cnt_q <= burst_cnt_d;
    end
`endif

    // ---------------------------------------------------------------- RX
    typedef enum logic [1:0] {R_NORMAL, R_MARK, R_ESC} rx_st_t;

    rx_st_t         rx_st_q, rx_st_d;
    logic [CW-1:0]  rx_ch_q, rx_ch_d;
    logic           rx_discard_q, rx_discard_d;
    logic           rx_full_q, rx_full_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           take, deliver;
    logic [7:0]     dbyte;

    // Accepting only when empty means rx_ch never changes under a held byte.
    assign phy_out_ready = ~rx_full_q;
    assign take          = phy_out_valid & ~rx_full_q;
    assign rx_data       = rx_data_q;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++)
            rx_valid[i] = rx_full_q & (rx_ch_q == CW'(i));
    end

    always_comb begin
        rx_st_d      = rx_st_q;
        rx_ch_d      = rx_ch_q;
        rx_discard_d = rx_discard_q;
        rx_full_d    = rx_full_q;
        rx_data_d    = rx_data_q;
        deliver      = 1'b0;
        dbyte        = phy_out_data;
        if (rx_full_q && rx_ready[rx_ch_q]) rx_full_d = 1'b0;
        if (take) begin
            case (rx_st_q)
                R_NORMAL: begin
                    if (phy_out_data == MARK)     rx_st_d = R_MARK;
                    else if (phy_out_data == ESC) rx_st_d = R_ESC;
                    else                          deliver = 1'b1;
                end
                R_MARK: begin
                    if (phy_out_data == MARK) begin
                        rx_st_d = R_MARK;
                    end else if (phy_out_data < 8'(CHANNELS)) begin
                        rx_ch_d      = phy_out_data[CW-1:0];
                        rx_discard_d = 1'b0;
                        rx_st_d      = R_NORMAL;
                    end else begin
                        rx_discard_d = 1'b1;
                        rx_st_d      = R_NORMAL;
                    end
                end
                R_ESC: begin
                    if (phy_out_data == MARK) begin
                        rx_st_d = R_MARK;       // aborted escape, nothing delivered
                    end else begin
                        deliver = 1'b1;
                        dbyte   = phy_out_data ^ 8'h20;
                        rx_st_d = R_NORMAL;
                    end
                end
                default: rx_st_d = R_NORMAL;
            endcase
        end
        if (deliver && !rx_discard_q) begin
            rx_data_d = dbyte;
            rx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            rx_st_q      <= R_NORMAL;
            rx_ch_q      <= '0;
            rx_discard_q <= 1'b0;
            rx_full_q    <= 1'b0;
            rx_data_q    <= '0;
        end else begin
            rx_st_q      <= rx_st_d;
            rx_ch_q      <= rx_ch_d;
            rx_discard_q <= rx_discard_d;
            rx_full_q    <= rx_full_d;
            rx_data_q    <= rx_data_d;
        end
    end
endmodule

// File: tb/tb_peridot_ft245_chmux.sv
module tb_peridot_ft245_chmux;
    logic        clock_sig = 1'b0;
    logic        reset_sig = 1'b1;
    logic        phy_in_ready, phy_in_valid;
    logic [7:0]  phy_in_data;
    logic        phy_out_ready, phy_out_valid;
    logic [7:0]  phy_out_data;
    logic [1:0]  tx_valid, tx_eop, tx_ready, rx_valid, rx_ready;
    logic [15:0] tx_data;
    logic [7:0]  rx_data;

    always #5 clock_sig = ~clock_sig;

    peridot_ft245_chmux #(.CHANNELS(2), .BURST_LIMIT(4)) dut (
        .clock_sig(clock_sig), .reset_sig(reset_sig),
        .phy_in_ready(phy_in_ready), .phy_in_valid(phy_in_valid), .phy_in_data(phy_in_data),
        .phy_out_ready(phy_out_ready), .phy_out_valid(phy_out_valid), .phy_out_data(phy_out_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_eop(tx_eop), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
    );

    int n_cmp = 0, n_bad = 0;
    logic [8:0] txq0[$], txq1[$];   // {eop, byte}
    logic [7:0] phyq[$];
    logic [8:0] rxq[$];             // {channel, byte}
    int rdy_cnt0 = 0, rdy_cnt1 = 0, bad_rdy = 0;

    // Source model: present queue heads, changed only on the falling edge.
    always @(negedge clock_sig) begin
        tx_valid[0] = (txq0.size() > 0);
        tx_data[7:0] = (txq0.size() > 0) ? txq0[0][7:0] : 8'h00;
        tx_eop[0] = (txq0.size() > 0) ? txq0[0][8] : 1'b0;
        tx_valid[1] = (txq1.size() > 0);
        tx_data[15:8] = (txq1.size() > 0) ? txq1[0][7:0] : 8'h00;
        tx_eop[1] = (txq1.size() > 0) ? txq1[0][8] : 1'b0;
    end

    always @(posedge clock_sig) begin
        if (!reset_sig) begin
            if (phy_in_valid && phy_in_ready) phyq.push_back(phy_in_data);
            if (tx_ready[0]) begin
                rdy_cnt0++;
                if (tx_valid[0] && txq0.size() > 0) txq0.delete(0); else bad_rdy++;
            end
            if (tx_ready[1]) begin
                rdy_cnt1++;
                if (tx_valid[1] && txq1.size() > 0) txq1.delete(0); else bad_rdy++;
            end
            if (rx_valid[0] && rx_ready[0]) rxq.push_back({1'b0, rx_data});
            if (rx_valid[1] && rx_ready[1]) rxq.push_back({1'b1, rx_data});
        end
    end

    task automatic do_reset();
        reset_sig = 1'b1;
        txq0.delete(); txq1.delete(); phyq.delete(); rxq.delete();
        tx_valid = '0; tx_data = '0; tx_eop = '0;
        phy_in_ready = 1'b1; phy_out_valid = 1'b0; phy_out_data = '0; rx_ready = 2'b11;
        repeat (2) @(negedge clock_sig);
        reset_sig = 1'b0;
        rdy_cnt0 = 0; rdy_cnt1 = 0; bad_rdy = 0;
    endtask

    task automatic wait_phy(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (phyq.size() >= n) begin ok = 1'b1; break; end
            @(negedge clock_sig);
        end
        repeat (4) @(negedge clock_sig);
    endtask

    task automatic send_rx(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        phy_out_valid = 1'b1;
        phy_out_data  = b;
        for (int c = 0; c < 100; c++) begin
            if (phy_out_ready) begin ok = 1'b1; break; end
            @(negedge clock_sig);
        end
        @(negedge clock_sig);
        phy_out_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({phy_in_valid, phy_in_data, tx_ready, rx_valid, rx_data, phy_out_ready} !== {1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_outputs got vld=%b d=%h txr=%b rxv=%b rxd=%h por=%b want 0 00 00 00 00 1",
                     phy_in_valid, phy_in_data, tx_ready, rx_valid, rx_data, phy_out_ready);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp[$] = '{8'h7C, 8'h00, 8'h11, 8'h22};
        bit ok;
        txq0.push_back({1'b0, 8'h11}); txq0.push_back({1'b1, 8'h22});
        wait_phy(exp.size(), ok);
        n_cmp++;
        if (!ok || phyq.size() != exp.size()) begin
            n_bad++; $display("FAIL single_count got %0d want %0d", phyq.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < phyq.size(); i++) begin
            n_cmp++;
            if (phyq[i] !== exp[i]) begin
                n_bad++; $display("FAIL single_byte%0d got %h want %h", i, phyq[i], exp[i]);
            end
        end
        n_cmp++;
        if (rdy_cnt0 != 2 || rdy_cnt1 != 0) begin
            n_bad++; $display("FAIL single_ready_pulses got %0d/%0d want 2/0", rdy_cnt0, rdy_cnt1);
        end
    endtask

    task automatic test_escape();
        logic [7:0] exp[$] = '{8'h7C, 8'h01, 8'h7D, 8'h5C, 8'h7D, 8'h5D};
        bit ok;
        phyq.delete();
        txq1.push_back({1'b0, 8'h7C}); txq1.push_back({1'b1, 8'h7D});
        wait_phy(exp.size(), ok);
        n_cmp++;
        if (!ok || phyq.size() != exp.size()) begin
            n_bad++; $display("FAIL escape_count got %0d want %0d", phyq.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < phyq.size(); i++) begin
            n_cmp++;
            if (phyq[i] !== exp[i]) begin
                n_bad++; $display("FAIL escape_byte%0d got %h want %h", i, phyq[i], exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$] = '{8'h7C, 8'h00, 8'h31, 8'h32, 8'h33, 8'h7C, 8'h01,
                               8'h41, 8'h42, 8'h43, 8'h51, 8'h52};
        bit ok;
        phyq.delete(); rdy_cnt0 = 0; rdy_cnt1 = 0;
        txq0.push_back({1'b0, 8'h31}); txq0.push_back({1'b0, 8'h32}); txq0.push_back({1'b1, 8'h33});
        txq1.push_back({1'b0, 8'h41}); txq1.push_back({1'b0, 8'h42}); txq1.push_back({1'b1, 8'h43});
        txq1.push_back({1'b0, 8'h51}); txq1.push_back({1'b1, 8'h52});
        wait_phy(exp.size(), ok);
        n_cmp++;
        if (!ok || phyq.size() != exp.size()) begin
            n_bad++; $display("FAIL rr_count got %0d want %0d", phyq.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < phyq.size(); i++) begin
            n_cmp++;
            if (phyq[i] !== exp[i]) begin
                n_bad++; $display("FAIL rr_byte%0d got %h want %h", i, phyq[i], exp[i]);
            end
        end
        n_cmp++;
        if (rdy_cnt0 != 3 || rdy_cnt1 != 5 || bad_rdy != 0) begin
            n_bad++; $display("FAIL rr_ready_pulses got %0d/%0d stray=%0d want 3/5 stray=0", rdy_cnt0, rdy_cnt1, bad_rdy);
        end
    endtask

    task automatic test_rx();
        logic [7:0] stim[$] = '{8'h7C, 8'h01, 8'h41, 8'h7D, 8'h5C, 8'h7C, 8'h05, 8'h99, 8'h7C, 8'h00, 8'h42};
        logic [8:0] exp[$]  = '{9'h141, 9'h17C, 9'h042};
        bit ok, all_ok;
        rxq.delete(); rx_ready = 2'b11; all_ok = 1'b1;
        foreach (stim[i]) begin
            send_rx(stim[i], ok);
            all_ok &= ok;
        end
        repeat (4) @(negedge clock_sig);
        n_cmp++;
        if (!all_ok || rxq.size() != exp.size()) begin
            n_bad++; $display("FAIL rx_count got %0d accepted=%b want %0d accepted=1", rxq.size(), all_ok, exp.size());
        end
        for (int i = 0; i < exp.size() && i < rxq.size(); i++) begin
            n_cmp++;
            if (rxq[i] !== exp[i]) begin
                n_bad++; $display("FAIL rx_item%0d got %h want %h", i, rxq[i], exp[i]);
            end
        end
    endtask

    task automatic test_rx_stall();
        bit ok1, ok2, ok3, ok4, seen;
        rxq.delete(); rx_ready = 2'b01; seen = 1'b0;
        fork
            begin
                send_rx(8'h7C, ok1); send_rx(8'h01, ok2); send_rx(8'h55, ok3); send_rx(8'h66, ok4);
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clock_sig);
                    if (rx_valid[1]) begin seen = 1'b1; break; end
                end
                n_cmp++;
                if (!seen) begin n_bad++; $display("FAIL stall_valid_timeout got 0 want rx_valid[1]=1"); end
                for (int c = 0; c < 20; c++) begin
                    n_cmp++;
                    if ({phy_out_ready, rx_valid, rx_data} !== {1'b0, 2'b10, 8'h55}) begin
                        n_bad++;
                        $display("FAIL stall_hold c%0d got por=%b rxv=%b d=%h want 0 10 55", c, phy_out_ready, rx_valid, rx_data);
                    end
                    @(negedge clock_sig);
                end
                rx_ready = 2'b11;
            end
        join
        repeat (4) @(negedge clock_sig);
        n_cmp++;
        if (!(ok1 && ok2 && ok3 && ok4) || rxq.size() != 2) begin
            n_bad++; $display("FAIL stall_count got %0d want 2", rxq.size());
        end else begin
            n_cmp++;
            if (rxq[0] !== 9'h155 || rxq[1] !== 9'h166) begin
                n_bad++; $display("FAIL stall_items got %h %h want 155 166", rxq[0], rxq[1]);
            end
        end
    endtask

`ifdef PERIDOT_FT245_CHMUX_BURSTLIMIT_EN
    task automatic test_burst();
        logic [7:0] exp[$] = '{8'h7C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h7C, 8'h01,
                               8'hA0, 8'h7C, 8'h00, 8'h05, 8'h06};
        bit ok;
        do_reset();
        for (int i = 1; i <= 6; i++) txq0.push_back({(i == 6), 8'(i)});
        txq1.push_back({1'b1, 8'hA0});
        wait_phy(exp.size(), ok);
        n_cmp++;
        if (!ok || phyq.size() != exp.size()) begin
            n_bad++; $display("FAIL burst_count got %0d want %0d", phyq.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < phyq.size(); i++) begin
            n_cmp++;
            if (phyq[i] !== exp[i]) begin
                n_bad++; $display("FAIL burst_byte%0d got %h want %h", i, phyq[i], exp[i]);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0] exp[$] = '{8'h7C, 8'h00, 8'h10};
        bit found, ok;
        do_reset();
        txq1.push_back({1'b1, 8'h77});
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock_sig);
            if (phy_in_valid && phy_in_data == 8'h7C) begin found = 1'b1; break; end
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL midrst_hdr_timeout got no 7C want 7C"); end
        reset_sig = 1'b1;
        @(posedge clock_sig); #1;
        n_cmp++;
        if ({phy_in_valid, tx_ready} !== 3'b000) begin
            n_bad++; $display("FAIL midrst_valid got vld=%b txr=%b want 0 00", phy_in_valid, tx_ready);
        end
        do_reset();
        txq0.push_back({1'b1, 8'h10});
        wait_phy(exp.size(), ok);
        n_cmp++;
        if (!ok || phyq.size() != exp.size()) begin
            n_bad++; $display("FAIL midrst_count got %0d want %0d", phyq.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < phyq.size(); i++) begin
            n_cmp++;
            if (phyq[i] !== exp[i]) begin
                n_bad++; $display("FAIL midrst_byte%0d got %h want %h", i, phyq[i], exp[i]);
            end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single();
        test_escape();
        test_back_to_back();
        test_rx();
        test_rx_stall();
`ifdef PERIDOT_FT245_CHMUX_BURSTLIMIT_EN
        test_burst();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/peridot_ft245_chmux.md
Name: peridot_ft245_chmux

Overview:
- Channel multiplexer and arbiter in front of the FT245 async-FIFO phy's Avalon-ST byte ports.
- TX: shares the single phy TX stream between CHANNELS requesters with round-robin, packet-granular arbitration. Inserts a channel header whenever the owning channel changes, and escapes reserved bytes.
- RX: parses the same framing from the phy RX stream and steers payload bytes to per-channel sources.

Parameters:
- CHANNELS, 2, number of channels; legal 1..4.
- BURST_LIMIT, 64, max payload bytes per grant; used only with the optional feature; legal 1..255.

Ports:
- clock_sig  in  1  clock
- reset_sig  in  1  reset
- phy_in_ready  in  1  phy TX sink ready
- phy_in_valid  out  1  byte valid to phy TX
- phy_in_data  out  8  byte to phy TX
- phy_out_ready  out  1  ready to phy RX source
- phy_out_valid  in  1  phy RX byte valid
- phy_out_data  in  8  phy RX byte
- tx_valid  in  CHANNELS  per-channel TX valid
- tx_data  in  8*CHANNELS  per-channel TX byte; channel i at [8i+7:8i]
- tx_eop  in  CHANNELS  last byte of packet, qualified by tx_valid
- tx_ready  out  CHANNELS  per-channel TX accept
- rx_valid  out  CHANNELS  per-channel RX valid
- rx_data  out  8  RX byte, shared by all channels
- rx_ready  in  CHANNELS  per-channel RX ready

Behaviour:
- Reset and clock: reset reset_sig, asynchronous, active-high; clock clock_sig. Everything is posedge-clocked.
- Reset values: phy_in_valid=0, phy_in_data=0, tx_ready=0, rx_valid=0, rx_data=0, phy_out_ready=1. Internal reset values: tx_cur_ch=invalid (forces a header on first grant), rr_ptr=0, rx_ch=0, rx_discard=0.
- Framing constants: MARK=0x7C, ESC=0x7D.
  - Header = MARK followed by a channel byte 0x00..CHANNELS-1.
  - A payload byte equal to MARK or ESC is sent as ESC, then (byte XOR 0x20).
- Phy TX handshake: phy_in_valid/phy_in_data come from one output register. A byte transfers on phy_in_valid & phy_in_ready. Data is held stable while valid.
- The register loads only when empty or transferring in the same cycle.
- TX FSM:
  - IDLE:
    - Choose grant g = first i with tx_valid[i], searching from rr_ptr upward with wrap.
    - If g != tx_cur_ch -> HDR_MARK, else -> DATA.
    - No request -> stay in IDLE.
  - HDR_MARK: load 0x7C -> HDR_CH.
  - HDR_CH: load g, set tx_cur_ch=g -> DATA.
  - DATA:
    - When the output register can load and tx_valid[g]=1: pulse tx_ready[g] for exactly 1 cycle, consuming the byte that cycle.
    - Byte is 0x7C/0x7D: load 0x7D, save the byte -> ESC_DATA. Otherwise load the byte directly.
    - Consumed byte had tx_eop=1: set rr_ptr=(g+1) mod CHANNELS -> IDLE (after ESC_DATA if escaping).
  - ESC_DATA: load saved^0x20 -> DATA, or -> IDLE if the saved byte was eop.
- Latency and ordering: 1 cycle from tx_ready to phy_in_valid. Other channels are never granted mid-packet. tx_ready is never asserted for a non-granted channel.
- CHANNELS=1: the header is still emitted once after reset.
- RX parser states:
  - NORMAL:
    - 0x7C -> MARK.
    - 0x7D -> ESC.
    - Any other byte is delivered.
  - MARK:
    - 0x7C -> stay in MARK.
    - Byte < CHANNELS: rx_ch=byte, rx_discard=0 -> NORMAL.
    - Otherwise: rx_discard=1 -> NORMAL.
  - ESC:
    - 0x7C -> MARK; the escape is aborted and no byte is delivered.
    - Otherwise deliver byte^0x20 -> NORMAL.
- RX delivery:
  - A byte is consumed on phy_out_valid & phy_out_ready. phy_out_ready = ~rx_full.
  - Delivery loads rx_data and sets rx_full. rx_valid[i] = rx_full & (rx_ch==i).
  - rx_full clears on rx_ready[rx_ch]. rx_ch cannot change while rx_full.
  - Delivered bytes are dropped silently while rx_discard=1.
- RX throughput: 1 byte per 2 cycles is the maximum. This exceeds phy throughput.
- Reset mid-operation: all FSMs return to IDLE/NORMAL. A partially sent header or escape pair is abandoned. The phy shares the same reset.

Optional Feature:
- Macro: PERIDOT_FT245_CHMUX_BURSTLIMIT_EN.
- Defined:
  - A per-grant counter counts consumed payload bytes; escape bytes are not counted.
  - After BURST_LIMIT bytes without eop, the grant is released: rr_ptr=(g+1) mod CHANNELS -> IDLE. tx_cur_ch is kept.
  - The next grant emits a header if a different channel wins. The packet resumes later with a fresh header when its channel is re-granted.
- Undefined: the counter is not built; BURST_LIMIT is ignored; the grant is held until eop.

Test Plan:
- After reset, ch0 sends 0x11, 0x22 with eop on 0x22, phy_in_ready always 1 -> phy receives 0x7C, 0x00, 0x11, 0x22. tx_ready[0] pulses twice.
- ch1 sends 0x7C, 0x7D with eop -> phy receives 0x7C, 0x01, 0x7D, 0x5C, 0x7D, 0x5D.
- ch0 and ch1 each hold a 3-byte packet, both valid, rr_ptr=0:
  - Order: header 0, 3 bytes of ch0, header 1, 3 bytes of ch1.
  - A second ch1 packet immediately after sends no header.
- RX stream 0x7C, 0x01, 0x41, 0x7D, 0x5C, 0x7C, 0x05, 0x99, 0x7C, 0x00, 0x42 -> rx_valid[1] delivers 0x41 then 0x7C. 0x99 is dropped. rx_valid[0] delivers 0x42.
- rx_ready[1]=0 for 20 cycles with a byte pending -> phy_out_ready=0 and rx_valid[1] stays 1 with rx_data stable. No RX byte is lost when ready rises.
- BURSTLIMIT_EN with BURST_LIMIT=4:
  - Setup: ch0 has a 6-byte packet and ch1 a 1-byte packet.
  - Expected phy bytes: 7C 00, b0..b3, 7C 01, c0, 7C 00, b4, b5.
  - Assert reset mid-HDR_CH -> phy_in_valid is 0 on the next edge.
